// File: rtl/write_buffer.sv
// Posted write buffer between a write-through cache and external memory, with
// same-cycle read forwarding from buffered entries and read-after-write ordering.
module write_buffer #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic [WORD_SIZE-1:0]  up_data_in,
  input  logic                  up_wr,
  input  logic                  up_re,
  output logic [WORD_SIZE-1:0]  up_data_out,
  output logic                  up_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_data_out,
  input  logic [WORD_SIZE-1:0]  mem_data_in,
  output logic                  mem_wr,
  output logic                  mem_re,
  input  logic                  mem_ready,
  input  logic                  mem_err,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  logic [ADDR_WIDTH-1:0] ent_addr_q [DEPTH];
  logic [WORD_SIZE-1:0]  ent_data_q [DEPTH];

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q, state_d;
  logic                  err_q, err_d;
  logic [WORD_SIZE-1:0]  rd_data_q, rd_data_d;
  logic                  mem_wr_q, mem_wr_d, mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]  mem_data_q, mem_data_d;

  logic                  push, pop, hit, fwd, resp;
  logic [WORD_SIZE-1:0]  hit_data;
  logic [PW-1:0]         idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = up_wr && !full;
  assign resp  = (state_q == S_RESP);

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (ent_addr_q[idx][ADDR_WIDTH-1:2] == up_addr[ADDR_WIDTH-1:2])) begin
        hit      = 1'b1;
        hit_data = ent_data_q[idx];
      end
    end
  end

  assign fwd         = up_re && !up_wr && hit;
  assign up_ack      = push || fwd || resp;
  assign up_data_out = resp ? rd_data_q : (fwd ? hit_data : '0);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    mem_wr_d   = mem_wr_q;
    mem_re_d   = mem_re_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d    = S_WRITE;
          mem_wr_d   = 1'b1;
          mem_addr_d = ent_addr_q[head_q];
          mem_data_d = ent_data_q[head_q];
        end else if (up_re && !up_wr) begin
          // Buffer is empty here, so this read cannot have been forwarded.
          state_d    = S_READ;
          mem_re_d   = 1'b1;
          mem_addr_d = up_addr;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          pop        = 1'b1;
          state_d    = S_IDLE;
          mem_wr_d   = 1'b0;
          mem_addr_d = '0;
          mem_data_d = '0;
          if (mem_err) err_d = 1'b1;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          rd_data_d  = mem_data_in;
          state_d    = S_RESP;
          mem_re_d   = 1'b0;
          mem_addr_d = '0;
          if (mem_err) err_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        rd_data_d = '0;
      end
    endcase
  end

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      mem_wr_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      mem_wr_q   <= mem_wr_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Entry storage needs no reset; validity is carried by count/head.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= up_addr;
      ent_data_q[tail_q] <= up_data_in;
    end
  end

  assign mem_wr       = mem_wr_q;
  assign mem_re       = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_write_buffer;
  localparam int AW = 32;
  localparam int WS = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] up_addr;
  logic [WS-1:0] up_data_in, up_data_out, mem_data_out, mem_data_in;
  logic          up_wr, up_re, up_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_wr, mem_re, mem_ready, mem_err;
  logic          full, empty, err;

  always #5 clk = ~clk;

  write_buffer #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .up_addr(up_addr), .up_data_in(up_data_in),
    .up_wr(up_wr), .up_re(up_re), .up_data_out(up_data_out), .up_ack(up_ack),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_wr(mem_wr), .mem_re(mem_re), .mem_ready(mem_ready), .mem_err(mem_err),
    .full(full), .empty(empty), .err(err)
  );

  int vectors = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: answers a request after mem_lat cycles unless stalled.
  bit            mem_stall = 0;
  int            mem_lat = 0;
  bit            err_inject = 0;
  logic [WS-1:0] rd_val = '0;
  int            wait_cnt = 0;

  always @(posedge clk) begin
    #1;
    mem_ready   = 1'b0;
    mem_err     = 1'b0;
    mem_data_in = rd_val;
    if ((mem_wr || mem_re) && !mem_stall && rst) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_err   = err_inject;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Reference model: the buffer is an ordered queue of posted writes.
  typedef struct { logic [AW-1:0] a; logic [WS-1:0] d; } ent_t;
  ent_t          mq[$];
  bit            m_err = 0;
  bit            resp_pend = 0;
  logic [WS-1:0] resp_val = '0;
  bit            prev_done = 0;

  always @(negedge clk) begin : compare
    bit            wr_acc, hit, fwd, exp_ack;
    logic [WS-1:0] hd;
    if (!rst) begin
      mq.delete();
      m_err = 0; resp_pend = 0; prev_done = 0;
      chk("rst_up_ack", up_ack, 0);
      chk("rst_up_data_out", up_data_out, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data_out", mem_data_out, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_err", err, 0);
    end else begin
      wr_acc = up_wr && (mq.size() < DEPTH);
      hit = 0; hd = '0;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a[AW-1:2] == up_addr[AW-1:2]) begin hit = 1; hd = mq[i].d; end
      fwd = up_re && !up_wr && hit;
      exp_ack = wr_acc || fwd || resp_pend;
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("err", err, m_err);
      chk("up_ack", up_ack, exp_ack);
      if (!exp_ack) chk("up_data_out_idle", up_data_out, 0);
      else if (resp_pend) chk("up_data_out_resp", up_data_out, resp_val);
      else if (fwd) chk("up_data_out_fwd", up_data_out, hd);
      if (mem_wr) begin
        chk("mem_wr_has_entry", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          chk("mem_wr_addr", mem_addr, mq[0].a);
          chk("mem_wr_data", mem_data_out, mq[0].d);
        end
      end
      if (mem_re) begin
        chk("mem_re_after_drain", mq.size(), 0);
        chk("mem_re_pending_read", up_re && !up_wr, 1);
        chk("mem_re_addr", mem_addr, up_addr);
      end
      chk("mem_wr_re_exclusive", mem_wr && mem_re, 0);
      if (prev_done) chk("mem_idle_gap", mem_wr || mem_re, 0);
      prev_done = mem_ready && (mem_wr || mem_re);
      if (mem_ready && mem_err && (mem_wr || mem_re)) m_err = 1;
      if (mem_wr && mem_ready && mq.size() > 0) void'(mq.pop_front());
      if (wr_acc) mq.push_back('{a: up_addr, d: up_data_in});
      resp_pend = mem_re && mem_ready;
      resp_val  = mem_data_in;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    @(negedge clk);
    while (!up_ack && n < 200) begin @(negedge clk); n++; end
    chk(nm, up_ack, 1);
  endtask

  task automatic write_req(input logic [AW-1:0] a, input logic [WS-1:0] d);
    up_wr = 1; up_addr = a; up_data_in = d;
    wait_ack("write_ack_timeout");
    tick();
    up_wr = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!(empty && !mem_wr && !mem_re) && n < 300) begin @(negedge clk); n++; end
    chk(nm, empty && !mem_wr && !mem_re, 1);
    tick();
  endtask

  task automatic wait_mem_wr(input string nm);
    int n = 0;
    @(negedge clk);
    while (!mem_wr && n < 200) begin @(negedge clk); n++; end
    chk(nm, mem_wr, 1);
  endtask

  initial begin : stim
    int acks, n;
    bit got, seen_wr, seen_re;
    rst = 0; up_wr = 0; up_re = 0; up_addr = '0; up_data_in = '0;
    mem_ready = 0; mem_err = 0; mem_data_in = '0;
    repeat (3) @(negedge clk);
    tick(); rst = 1;

    // Single posted write drains to memory.
    mem_lat = 2;
    write_req(32'hF0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("w1_empty_after_push", empty, 0);
    wait_mem_wr("w1_mem_wr");
    chk("w1_mem_addr", mem_addr, 32'hF0);
    chk("w1_mem_data", mem_data_out, 32'hFFFF_FFFF);
    wait_idle("w1_drained");
    chk("w1_empty_end", empty, 1);

    // Five back-to-back writes into a stalled memory.
    mem_stall = 1; mem_lat = 0;
    up_wr = 1; up_addr = 32'h100; up_data_in = 32'hD0; acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); got = up_ack;
      if (got) acks++;
      tick();
      if (got) begin up_addr = up_addr + 4; up_data_in = up_data_in + 1; end
    end
    chk("full_four_acked", acks, 4);
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_fifth_refused", up_ack, 0);
    tick(); mem_stall = 0;
    wait_ack("full_fifth_acked");
    tick(); up_wr = 0;
    wait_idle("full_drained");

    // Forwarding from the youngest of two same-address entries.
    mem_stall = 1;
    write_req(32'h10, 32'hA);
    write_req(32'h10, 32'hB);
    up_re = 1; up_addr = 32'h10;
    @(negedge clk);
    chk("fwd_ack", up_ack, 1);
    chk("fwd_data", up_data_out, 32'hB);
    chk("fwd_no_mem_re", mem_re, 0);
    tick(); up_addr = 32'h13;
    @(negedge clk);
    chk("fwd_word_match", up_data_out, 32'hB);
    tick(); up_re = 0; mem_stall = 0;
    wait_idle("fwd_drained");

    // Read miss waits for the older write to drain.
    mem_stall = 1;
    write_req(32'h20, 32'h5);
    rd_val = 32'h77; mem_lat = 1;
    up_re = 1; up_addr = 32'h40; mem_stall = 0;
    seen_wr = 0; seen_re = 0; n = 0;
    do begin
      @(negedge clk);
      if (mem_wr && mem_addr == 32'h20) seen_wr = 1;
      if (mem_re) begin chk("miss_read_after_write", seen_wr, 1); seen_re = 1; end
      n++;
    end while (!up_ack && n < 200);
    chk("miss_ack", up_ack, 1);
    chk("miss_data", up_data_out, 32'h77);
    chk("miss_used_memory", seen_re, 1);
    tick(); up_re = 0;
    wait_idle("miss_idle");

    // Write and read together: write wins.
    up_wr = 1; up_re = 1; up_addr = 32'h500; up_data_in = 32'h55;
    @(negedge clk);
    chk("both_write_acked", up_ack, 1);
    tick(); up_wr = 0; up_re = 0;
    wait_idle("both_drained");

    // Streaming writes with a fast memory: push and pop coincide.
    mem_lat = 0; up_wr = 1; up_addr = 32'h300; up_data_in = 32'h1; acks = 0; n = 0;
    while (acks < 6 && n < 100) begin
      @(negedge clk); got = up_ack;
      tick();
      if (got) begin acks++; up_addr = up_addr + 4; up_data_in = up_data_in + 1; end
      n++;
    end
    up_wr = 0;
    chk("stream_acks", acks, 6);
    wait_idle("stream_drained");

    // Sticky memory error.
    err_inject = 1;
    write_req(32'h30, 32'h1);
    wait_idle("err_drained");
    chk("err_set", err, 1);
    err_inject = 0;
    write_req(32'h34, 32'h2);
    wait_idle("err_drained2");
    chk("err_sticky", err, 1);
    rst = 0; #1;
    chk("err_cleared_by_reset", err, 0);
    tick(); rst = 1;

    // Reset in the middle of a memory write.
    mem_stall = 1;
    write_req(32'h200, 32'h1);
    write_req(32'h204, 32'h2);
    write_req(32'h208, 32'h3);
    wait_mem_wr("rst_mid_mem_wr_seen");
    tick(); rst = 0; #1;
    chk("rst_mid_mem_wr_low", mem_wr, 0);
    chk("rst_mid_empty", empty, 1);
    tick(); rst = 1; mem_stall = 0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_mid_no_traffic", mem_wr || mem_re, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameters: WORD_SIZE, default 32, data word width; ADDR_WIDTH, default 32, byte address width; DEPTH, default 4, entry count, power of two, at least 2.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port up_addr  input  ADDR_WIDTH  request byte address from the write-through cache.
REQ-005 SHALL have port up_data_in  input  WORD_SIZE  write data from the cache.
REQ-006 SHALL have port up_wr  input  1  cache write request, held until up_ack.
REQ-007 SHALL have port up_re  input  1  cache read request, held until up_ack.
REQ-008 SHALL have port up_data_out  output  WORD_SIZE  read data to the cache.
REQ-009 SHALL have port up_ack  output  1  one-cycle completion strobe to the cache.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  external memory address.
REQ-011 SHALL have port mem_data_out  output  WORD_SIZE  write data to external memory.
REQ-012 SHALL have port mem_data_in  input  WORD_SIZE  read data from external memory, valid while mem_ready=1.
REQ-013 SHALL have port mem_wr  output  1  memory write request.
REQ-014 SHALL have port mem_re  output  1  memory read request.
REQ-015 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-016 SHALL have port mem_err  input  1  memory error, sampled with mem_ready.
REQ-017 SHALL have ports full, empty, err  output  1 each  buffer full, buffer empty, sticky memory error.

Function
REQ-018 SHALL hold a circular FIFO of DEPTH {address, data} entries with head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-019 SHALL assert full when count equals DEPTH and empty when count equals 0, both decoded combinationally from count.
REQ-020 SHALL accept a write when up_wr=1 and full=0: up_ack=1 combinationally in the same cycle, and the entry is written at tail on that clock edge.
REQ-021 SHALL NOT merge entries; a repeated address SHALL be appended as a new entry.
REQ-022 SHALL give up_wr priority over up_re when both are asserted; up_re is ignored that cycle.
REQ-023 SHALL forward read data when up_re=1, up_wr=0, and the word address (up_addr[ADDR_WIDTH-1:2]) matches any valid entry: up_ack=1 and up_data_out equal to the youngest matching entry's data, combinationally in the same cycle, with no memory access.
REQ-024 SHALL run a four-state FSM: IDLE, WRITE, READ, RESP.
REQ-025 In IDLE, if empty=0, the FSM SHALL go to WRITE; else, if an unforwarded up_re is pending, it SHALL latch up_addr and go to READ.
REQ-026 In WRITE, mem_wr=1, mem_addr=head address, mem_data_out=head data, all held stable; on mem_ready=1 the head SHALL pop and the FSM SHALL return to IDLE.
REQ-027 In READ, mem_re=1 with mem_addr equal to the latched address; on mem_ready=1 mem_data_in SHALL be registered and the FSM SHALL go to RESP.
REQ-028 In RESP, up_ack=1 for exactly one cycle with up_data_out equal to the registered data, then IDLE.
REQ-029 A read miss therefore SHALL wait until all older writes have drained (read-after-write ordering).
REQ-030 mem_wr and mem_re SHALL be mutually exclusive and deasserted for at least one cycle (IDLE) between transactions.
REQ-031 A push and a pop in the same cycle SHALL leave count unchanged; a push while full SHALL be refused (up_ack=0), and the cache stalls.
REQ-032 Writes SHALL continue to be accepted while in WRITE, READ, or RESP, subject to full.
REQ-033 mem_err=1 coincident with mem_ready=1 SHALL set err, which stays set until reset; the transaction still completes (pop or respond).
REQ-034 up_data_out SHALL be 0 whenever up_ack=0.

Reset
REQ-035 While rst=0, asynchronously: FIFO emptied (count, head, tail = 0), FSM = IDLE, err=0, up_ack=0, up_data_out=0, mem_wr=0, mem_re=0, mem_addr=0, mem_data_out=0, empty=1, full=0.
REQ-036 Reset mid-transaction SHALL discard all pending entries and the in-flight request without completing it.

Verification
REQ-037 Write 0xF0 <- 0xFFFFFFFF -> up_ack same cycle; next cycle empty=0; mem_wr=1, mem_addr=0xF0 until mem_ready; then empty=1.
REQ-038 DEPTH=4, memory stalled: five back-to-back writes -> four acked, full=1, fifth held unacked until the first pop, then acked.
REQ-039 Buffer holds 0x10<-0xA then 0x10<-0xB; read 0x10 -> same-cycle up_ack, up_data_out=0xB, mem_re never asserted.
REQ-040 Buffer holds 0x20<-0x5; read 0x40 (memory returns 0x77) -> mem_wr for 0x20 completes first, then mem_re at 0x40, then RESP with up_data_out=0x77.
REQ-041 mem_err=1 with mem_ready on a drain -> err=1 sticky, entry popped; rst=0 -> err=0.
REQ-042 rst=0 asserted while mem_wr=1 with 3 entries -> mem_wr=0 immediately, empty=1, no further memory traffic after release.
